// File: rtl/hist_pingpong_builder_if.sv
// Event-in / readout-out bundle of the ping-pong histogram builder.
// The builder takes the slave side; the event source and the readout
// consumer take the master side.
interface hist_pingpong_builder_if #(
    parameter int BIN_AW = 3,
    parameter int CNT_W  = 8
);
    logic              wr_en;
    logic [BIN_AW-1:0] addr;
    logic              wr_ready;
    logic              his_num;
    logic              acq_done;
    logic              hist_done;
    logic              overrun;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_AW-1:0] out_bin;
    logic [CNT_W-1:0]  out_count;
    logic              out_last;

    modport master (
        output wr_en, addr, out_ready,
        input  wr_ready, his_num, acq_done, hist_done, overrun,
               out_valid, out_bin, out_count, out_last
    );

    modport slave (
        input  wr_en, addr, out_ready,
        output wr_ready, his_num, acq_done, hist_done, overrun,
               out_valid, out_bin, out_count, out_last
    );
endinterface

// File: rtl/hist_pingpong_builder.sv
// Ping-pong histogram builder: accumulates per-bin photon counts into one
// of two banks while the other, finished bank is streamed out and cleared.
module hist_pingpong_builder #(
    parameter int BIN_AW    = 3,
    parameter int CNT_W     = 8,
    parameter int DATA_NUM  = 2,
    parameter int PIXEL_NUM = 200,
    parameter int ACQ_NUM   = 33333
) (
    input logic                    clk,
    input logic                    res,
    hist_pingpong_builder_if.slave bus
);
    localparam int NBINS = 1 << BIN_AW;
    localparam int IN_W  = $clog2(DATA_NUM) + 1;
    localparam int PIX_W = $clog2(PIXEL_NUM) + 1;
    localparam int ACQ_W = $clog2(ACQ_NUM) + 1;

    localparam logic [IN_W-1:0]   IN_MAX   = IN_W'(DATA_NUM - 1);
    localparam logic [PIX_W-1:0]  PIX_MAX  = PIX_W'(PIXEL_NUM - 1);
    localparam logic [ACQ_W-1:0]  ACQ_MAX  = ACQ_W'(ACQ_NUM - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
    localparam logic [BIN_AW-1:0] BIN_LAST = '1;

    // ACC: accumulating, nothing to drain. DRAIN: accumulating while the
    // other bank streams out. HOLD: a second histogram finished before the
    // drain did, so input is stalled until the drain completes.
    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  bank [2][NBINS];
    logic [IN_W-1:0]   input_cnt;
    logic [PIX_W-1:0]  pixel_cnt;
    logic [ACQ_W-1:0]  acq_cnt;

    logic              his_num;
    logic              overrun;
    logic              acq_done;
    logic              hist_done;

    logic              s0_valid;
    logic [BIN_AW-1:0] s0_addr;
    logic              s0_tag;
    logic [CNT_W-1:0]  s0_rd;
    logic [CNT_W-1:0]  s0_inc;

    logic              out_valid;
    logic [BIN_AW-1:0] out_bin;
    logic              out_last;
    logic [1:0]        start_dly;
    logic              drain_bank;

    logic              wr_ready;
    logic              accept;
    logic              in_wrap;
    logic              pix_wrap;
    logic              hist_evt;
    logic              beat;
    logic              last_beat;
    logic              toggle_his;
    logic              start_drain;
    logic              set_overrun;

    // Event acceptance, counter wrap detection and readout handshake decode.
    always_comb begin
        wr_ready   = (state_q != HOLD);
        accept     = bus.wr_en & wr_ready;
        in_wrap    = accept & (input_cnt == IN_MAX);
        pix_wrap   = in_wrap & (pixel_cnt == PIX_MAX);
        hist_evt   = pix_wrap & (acq_cnt == ACQ_MAX);
        drain_bank = ~his_num;
        out_last   = out_valid & (out_bin == BIN_LAST);
        beat       = out_valid & bus.out_ready;
        last_beat  = beat & out_last;
        // The write of event t lands on the edge that registers event t+1,
        // so a same-bin follower already reads the updated value here.
        s0_rd      = bank[s0_tag][s0_addr];
        s0_inc     = (s0_rd == CNT_SAT) ? s0_rd : s0_rd + CNT_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= ACC;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update from the same pre-edge values, whatever the statement order.
            state_q <= state_d;
        end
    end

    // Next state plus bank-swap / drain-start / overrun decisions.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d     = state_q;
        toggle_his  = 1'b0;
        start_drain = 1'b0;
        set_overrun = 1'b0;
        unique case (state_q)
            ACC: begin
                if (hist_evt) begin
                    toggle_his  = 1'b1;
                    start_drain = 1'b1;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (hist_evt && last_beat) begin
                    // Old bank empties on this very edge: swap straight over.
                    toggle_his  = 1'b1;
                    start_drain = 1'b1;
                end else if (hist_evt) begin
                    set_overrun = 1'b1;
                    state_d     = HOLD;
                end else if (last_beat) begin
                    state_d     = ACC;
                end
            end
            HOLD: begin
                if (last_beat) begin
                    toggle_his  = 1'b1;
                    start_drain = 1'b1;
                    state_d     = DRAIN;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // Event / pixel / acquisition counters.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            input_cnt <= '0;
            pixel_cnt <= '0;
            acq_cnt   <= '0;
        end else if (accept) begin
            if (input_cnt == IN_MAX) begin
                input_cnt <= '0;
                if (pixel_cnt == PIX_MAX) begin
                    pixel_cnt <= '0;
                    if (acq_cnt == ACQ_MAX) acq_cnt <= '0;
                    else                    acq_cnt <= acq_cnt + ACQ_W'(1);
                end else begin
                    pixel_cnt <= pixel_cnt + PIX_W'(1);
                end
            end else begin
                input_cnt <= input_cnt + IN_W'(1);
            end
        end
    end

    // Bank select, sticky overrun and the boundary pulses.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            his_num   <= 1'b0;
            overrun   <= 1'b0;
            acq_done  <= 1'b0;
            hist_done <= 1'b0;
        end else begin
            acq_done  <= pix_wrap;
            hist_done <= hist_evt;
            if (toggle_his)  his_num <= ~his_num;
            if (set_overrun) overrun <= 1'b1;
        end
    end

    // Stage 0 of the increment pipeline: capture bin address and bank tag.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            s0_valid <= 1'b0;
            s0_addr  <= '0;
            s0_tag   <= 1'b0;
        end else begin
            s0_valid <= accept;
            s0_addr  <= bus.addr;
            s0_tag   <= his_num;
        end
    end

    // Bank storage: stage-1 saturating write and clear-on-read of drained bins.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            // NOTE: the banks are plain flops, so reset can clear them; a RAM
            // macro would instead need a clearing sweep after reset.
            for (int b = 0; b < NBINS; b++) begin
                bank[0][b] <= '0;
                bank[1][b] <= '0;
            end
        end else begin
            if (s0_valid) bank[s0_tag][s0_addr] <= s0_inc;
            if (beat)     bank[drain_bank][out_bin] <= '0;
        end
    end

    // Readout sequencer: two-cycle start delay so the final increment of the
    // finished bank has landed, then one bin per accepted beat.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            start_dly <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
        end else begin
            if (start_drain) begin
                start_dly <= 2'd2;
            end else if (start_dly != 2'd0) begin
                start_dly <= start_dly - 2'd1;
                if (start_dly == 2'd1) out_valid <= 1'b1;
            end
            if (beat) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_bin   <= '0;
                end else begin
                    out_bin   <= out_bin + BIN_AW'(1);
                end
            end
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.his_num   = his_num;
    assign bus.acq_done  = acq_done;
    assign bus.hist_done = hist_done;
    assign bus.overrun   = overrun;
    assign bus.out_valid = out_valid;
    assign bus.out_bin   = out_bin;
    assign bus.out_count = bank[drain_bank][out_bin];
    assign bus.out_last  = out_last;
endmodule

// File: tb/tb_hist_pingpong_builder.sv
// Bench for hist_pingpong_builder: a histogram-level model (queue of finished
// histograms, plain event counting) checked every cycle, plus hand-computed
// literal expectations for the directed scenarios.
module tb_hist_pingpong_builder;
    localparam int BIN_AW    = 3;
    localparam int CNT_W     = 4;
    localparam int DATA_NUM  = 2;
    localparam int PIXEL_NUM = 2;
    localparam int ACQ_NUM   = 2;
    localparam int NBINS     = 1 << BIN_AW;
    localparam int PER_ACQ   = DATA_NUM * PIXEL_NUM;
    localparam int PER_HIST  = PER_ACQ * ACQ_NUM;
    localparam int SAT       = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic res = 1'b1;

    hist_pingpong_builder_if #(.BIN_AW(BIN_AW), .CNT_W(CNT_W)) bus ();
    hist_pingpong_builder_if #(.BIN_AW(BIN_AW), .CNT_W(3))     bus3 ();

    hist_pingpong_builder #(
        .BIN_AW(BIN_AW), .CNT_W(CNT_W), .DATA_NUM(DATA_NUM),
        .PIXEL_NUM(PIXEL_NUM), .ACQ_NUM(ACQ_NUM)
    ) u_dut (.clk(clk), .res(res), .bus(bus));

    hist_pingpong_builder #(
        .BIN_AW(BIN_AW), .CNT_W(3), .DATA_NUM(DATA_NUM),
        .PIXEL_NUM(PIXEL_NUM), .ACQ_NUM(ACQ_NUM)
    ) u_dut3 (.clk(clk), .res(res), .bus(bus3));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int m_hist [2][NBINS];   // finished histograms awaiting / in readout
    int m_qn;                // number of finished histograms queued
    int m_acc  [NBINS];      // histogram being accumulated
    int m_ev;                // events accepted into the current histogram
    int m_bin;               // next bin expected on the readout
    int m_wait;              // cycles until the head histogram is presented
    bit m_his, m_ovr, exp_acq, exp_hist;

    int drains_done = 0;
    int cap [16][NBINS];     // DUT out_count captured per drain, per bin

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    function automatic void model_reset();
        m_qn = 0; m_ev = 0; m_bin = 0; m_wait = 0;
        m_his = 1'b0; m_ovr = 1'b0; exp_acq = 1'b0; exp_hist = 1'b0;
        for (int b = 0; b < NBINS; b++) begin
            m_acc[b] = 0; m_hist[0][b] = 0; m_hist[1][b] = 0;
        end
    endfunction

    // Compare DUT outputs with the model, then advance the model by what the
    // next rising edge will do with the inputs now on the bus.
    always @(negedge clk) begin : cmp
        bit v_exp;
        bit ev_acc;
        if (res) begin
            model_reset();
        end else begin
            v_exp = (m_qn > 0) && (m_wait == 0);
            check("wr_ready",  bus.wr_ready,  32'(m_qn < 2));
            check("his_num",   bus.his_num,   32'(m_his));
            check("overrun",   bus.overrun,   32'(m_ovr));
            check("acq_done",  bus.acq_done,  32'(exp_acq));
            check("hist_done", bus.hist_done, 32'(exp_hist));
            check("out_valid", bus.out_valid, 32'(v_exp));
            if (v_exp) begin
                check("out_bin",   bus.out_bin,   32'(m_bin));
                check("out_count", bus.out_count, 32'(sat(m_hist[0][m_bin])));
                check("out_last",  bus.out_last,  32'(m_bin == NBINS - 1));
            end

            if (m_wait > 0) m_wait--;
            exp_acq  = 1'b0;
            exp_hist = 1'b0;
            ev_acc   = bus.wr_en && (m_qn < 2);

            if (v_exp && bus.out_ready) begin
                if (drains_done < 16) cap[drains_done][m_bin] = int'(bus.out_count);
                if (m_bin == NBINS - 1) begin
                    for (int b = 0; b < NBINS; b++) m_hist[0][b] = m_hist[1][b];
                    m_qn--;
                    m_bin = 0;
                    drains_done++;
                    if (m_qn > 0) begin
                        m_his  = ~m_his;
                        m_wait = 2;
                    end
                end else begin
                    m_bin++;
                end
            end

            if (ev_acc) begin
                m_acc[bus.addr]++;
                m_ev++;
                if (m_ev % PER_ACQ == 0) exp_acq = 1'b1;
                if (m_ev == PER_HIST) begin
                    exp_hist = 1'b1;
                    m_ev = 0;
                    if (m_qn > 0) begin
                        m_ovr = 1'b1;
                    end else begin
                        m_his  = ~m_his;
                        m_wait = 2;
                    end
                    for (int b = 0; b < NBINS; b++) begin
                        m_hist[m_qn][b] = m_acc[b];
                        m_acc[b] = 0;
                    end
                    m_qn++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a);
        bus.wr_en = 1'b1;
        bus.addr  = BIN_AW'(a);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic send3(input int a);
        bus3.wr_en = 1'b1;
        bus3.addr  = BIN_AW'(a);
        step();
        bus3.wr_en = 1'b0;
    endtask

    task automatic wait_drains(input int n, input int budget);
        int k = 0;
        while (drains_done < n && k < budget) begin
            step();
            k++;
        end
        check("drain_timeout", 32'(drains_done >= n), 32'd1);
    endtask

    int s1_addr [8] = '{3, 3, 5, 3, 0, 7, 5, 3};
    int s1_exp  [8] = '{1, 0, 0, 4, 0, 2, 0, 1};
    int s4_addr [8] = '{1, 1, 2, 3, 5, 7, 7, 7};
    int s5_addr [8] = '{6, 5, 4, 6, 3, 2, 1, 0};
    bit bp_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int  k;
        bit  found;
        int  got;

        bus.wr_en = 1'b0;  bus.addr = '0;  bus.out_ready = 1'b1;
        bus3.wr_en = 1'b0; bus3.addr = '0; bus3.out_ready = 1'b1;
        repeat (3) step();
        res = 1'b0;
        step();
        check("rst_his_num",   bus.his_num,   0);
        check("rst_wr_ready",  bus.wr_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_overrun",   bus.overrun,   0);

        // Saturation with a 3-bit counter: 8 hits on bin 5 read back as 7.
        for (int i = 0; i < 8; i++) send3(5);
        found = 1'b0; got = 0; k = 0;
        while (!found && k < 30) begin
            if (bus3.out_valid && bus3.out_bin == 3'd5) begin
                found = 1'b1;
                got   = int'(bus3.out_count);
            end
            step();
            k++;
        end
        check("sat3_seen",  32'(found), 1);
        check("sat3_count", got, 7);

        // 1. Basic accumulation.
        for (int i = 0; i < 8; i++) send(s1_addr[i]);
        check("s1_hist_done", bus.hist_done, 1);
        check("s1_his_num",   bus.his_num,   1);
        check("s1_valid_t1",  bus.out_valid, 0);
        step();
        check("s1_valid_t1b", bus.out_valid, 0);
        step();
        check("s1_valid_t2",  bus.out_valid, 1);
        wait_drains(1, 40);
        for (int b = 0; b < NBINS; b++) check("s1_bin", cap[0][b], s1_exp[b]);

        // 2. Same-bin bursts: 20 events to bin 2, idle gap after each histogram.
        for (int i = 0; i < 20; i++) begin
            send(2);
            if (i == 7 || i == 15) repeat (4) step();
        end
        wait_drains(3, 60);
        check("s2_h1_bin2", cap[1][2], 8);
        check("s2_h2_bin2", cap[2][2], 8);
        check("s2_h2_bin3", cap[2][3], 0);

        // 3. Complete the half histogram, drain under 1,0,0,1 backpressure.
        send(6); send(1); send(6); send(2);
        k = 0;
        while (drains_done < 4 && k < 80) begin
            bus.out_ready = bp_pat[k % 4];
            step();
            k++;
        end
        bus.out_ready = 1'b1;
        check("s3_done", 32'(drains_done >= 4), 1);
        check("s3_bin2", cap[3][2], 5);
        check("s3_bin6", cap[3][6], 2);
        check("s3_bin1", cap[3][1], 1);

        // 4. Overrun: readout stalled while two histograms complete.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(4);
        for (int i = 0; i < 8; i++) send(s4_addr[i]);
        send(7);
        check("s4_overrun",  bus.overrun,  1);
        check("s4_wr_ready", bus.wr_ready, 0);
        bus.out_ready = 1'b1;
        wait_drains(6, 80);
        check("s4_his_num", bus.his_num, 0);
        check("s4_c_bin4",  cap[4][4], 8);
        check("s4_d_bin7",  cap[5][7], 3);
        check("s4_d_bin1",  cap[5][1], 2);

        // 5. Reset in the middle of a drain.
        for (int i = 0; i < 8; i++) send(6);
        found = 1'b0; k = 0;
        while (!found && k < 30) begin
            if (bus.out_valid && bus.out_bin == 3'd3) found = 1'b1;
            else step();
            k++;
        end
        check("s5_beat3_seen", 32'(found), 1);
        res = 1'b1;
        #1;
        check("s5_rst_valid",   bus.out_valid, 0);
        check("s5_rst_overrun", bus.overrun,   0);
        check("s5_rst_his_num", bus.his_num,   0);
        check("s5_rst_wr_rdy",  bus.wr_ready,  1);
        check("s5_rst_out_bin", bus.out_bin,   0);
        check("s5_rst_last",    bus.out_last,  0);
        repeat (2) step();
        res = 1'b0;
        step();
        for (int i = 0; i < 8; i++) send(s5_addr[i]);
        wait_drains(7, 40);
        check("s5_bin6", cap[6][6], 2);
        check("s5_bin0", cap[6][0], 1);
        check("s5_bin7", cap[6][7], 0);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hist_pingpong_builder.md
# hist_pingpong_builder

Parametrised ping-pong histogram builder for the dToF SiFH datapath. It accumulates per-bin photon counts from a timestamp/bin-address event stream into one of two register banks. It counts events per pixel, pixels per acquisition and acquisitions per histogram. When a histogram completes, it swaps banks and streams the finished bank out with a valid/ready handshake, clearing each bin as it is read. It sits between the TDC/bin-address stage and the peak-detect/data-formatting stage.

## Interface
Parameters:
- BIN_AW, 3: bin address width; NBINS = 2^BIN_AW bins per bank
- CNT_W, 8: bin counter width; saturating
- DATA_NUM, 2: events per pixel (≥1)
- PIXEL_NUM, 200: pixels per acquisition (≥1)
- ACQ_NUM, 33333: acquisitions per histogram (≥1)

Ports:
- clk  in  1  single clock, rising edge
- res  in  1  reset, asynchronous, active-high
- wr_en  in  1  event strobe; valid only when wr_ready=1
- addr  in  BIN_AW  bin index of event
- wr_ready  out  1  event accepted this cycle if wr_en=1
- his_num  out  1  bank currently accumulating
- acq_done  out  1  one-cycle pulse at each acquisition boundary
- hist_done  out  1  one-cycle pulse at each histogram completion
- overrun  out  1  sticky; a histogram completed before the previous drain finished
- out_valid  out  1  readout beat valid
- out_ready  in  1  readout consumer ready
- out_bin  out  BIN_AW  bin index of beat
- out_count  out  CNT_W  count of that bin
- out_last  out  1  high on the beat with out_bin = NBINS-1

## Operation
- Reset (res=1, asynchronous): both banks zeroed. All counters 0. his_num=0. wr_ready=1. All other outputs 0. State ACC.
- Accepted event (wr_en & wr_ready) is tagged with his_num.
  - Stage 0 registers addr and tag and reads the bin.
  - Stage 1 writes min(count+1, 2^CNT_W−1).
  - Back-to-back events to the same {tag, addr} forward the stage-1 result, so no increment is lost. N consecutive hits on one bin yield N, saturated.
- Counters: input_cnt 0..DATA_NUM−1 wraps → pixel_cnt 0..PIXEL_NUM−1 wraps → acq_cnt 0..ACQ_NUM−1 wraps. Each counter is $clog2(max)+1 wide and never exceeds its max−1.
- acq_done pulses when pixel_cnt wraps. hist_done pulses when acq_cnt wraps (the event that completes the histogram).
- States:
  - ACC: accumulate; no drain pending.
    - On the histogram-completing event: his_num toggles on that edge; the old bank is marked full; → DRAIN.
  - DRAIN: accumulate into the new bank while streaming the old bank.
    - out_bin runs 0..NBINS−1; out_count = old-bank value.
    - On each accepted beat (out_valid & out_ready) the old-bank bin is written to 0.
    - After the out_last beat → ACC.
    - If a histogram completes while in DRAIN: overrun←1 (sticky until res), his_num does NOT toggle, → HOLD.
  - HOLD: wr_ready=0, events dropped, counters frozen. Drain continues. After out_last is accepted: his_num toggles, the completed bank is marked full, wr_ready←1, → DRAIN.
- out_bin/out_count/out_last are held stable while out_valid & ~out_ready.
- The stage-1 write of the completing event and any drain clear target different banks. No port conflict.

## Timing
- Event accepted at edge t: the bin holds its new value after edge t+1. Forwarding covers a same-bin event at t+1.
- The completing event at edge t toggles his_num at edge t. An event at t+1 goes to the new bank.
- hist_done and acq_done are high in the cycle following the accepting edge, for one cycle.
- First out_valid is at edge t+2, after the final old-bank write lands at t+1. Then one beat per cycle while out_ready=1. A full drain takes NBINS cycles minimum.
- In HOLD, wr_ready falls the cycle after the completing edge. It rises the cycle after out_last is accepted; the next drain's out_valid follows 2 cycles later.
- res asserted mid-drain or mid-pipeline: immediate return to reset values; in-flight increment discarded; no partial beat.

## Test plan
Parameters for all scenarios: BIN_AW=3, CNT_W=4, DATA_NUM=2, PIXEL_NUM=2, ACQ_NUM=2 (8 events per histogram).
1. Basic accumulation: 8 events, addr=3,3,5,3,0,7,5,3, out_ready=1 → acq_done after events 4 and 8; hist_done after event 8; his_num 0→1; stream bins 0..7 = 1,0,0,4,0,2,0,1; out_last on bin 7; old bank reads all zero afterwards.
2. Saturation and forwarding: 20 consecutive events to addr=2 (spans 2.5 histograms) → bin 2 counts 8, 8, none lost; separately, CNT_W=3 with 8 hits on one bin → out_count=7.
3. Backpressure: out_ready toggled 1,0,0,1,… during drain → each beat held stable until accepted; no bin skipped or repeated.
4. Overrun: out_ready=0 held while 16 events arrive → overrun=1, wr_ready=0, the 17th event dropped; after releasing out_ready, two full drains occur, his_num ends at 0, and the second histogram's counts are exact.
5. Reset mid-drain: assert res at beat 3 → all outputs at reset values asynchronously; after release, 8 fresh events give counts that contain no stale data.
